// File: rtl/ktc32_mem_pkg.sv
// Shared types and widths for the RAM port arbiter.
package ktc32_mem_pkg;
   localparam int ADDR_W   = 16;
   localparam int RAM_WD_W = 16;
   localparam int RAM_RD_W = 32;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_HI  = 2'd1,
      RMW_WR = 2'd2
   } arb_state_t;
endpackage

// File: rtl/ram_arbiter.sv
// Shares one RAM port between fetch and load/store; splits word stores into two
// half-writes and turns byte stores into read-modify-write.
module ram_arbiter
   import ktc32_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [RAM_RD_W-1:0] if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [1:0]          d_size,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [31:0]         d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [RAM_RD_W-1:0] d_rdata,
   output logic                d_wack,
   output logic                ram_we,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [RAM_WD_W-1:0] ram_wd,
   input  logic [RAM_RD_W-1:0] ram_data
);

   arb_state_t          r_state;
   logic                r_last_data;
   logic [ADDR_W-1:0]   r_addr;
   logic [RAM_WD_W-1:0] r_wd;

   logic w_idle, w_d_gnt, w_if_gnt, w_is_byte, w_is_half;

   assign w_idle    = (r_state == IDLE) && !rst;
   assign w_is_byte = (d_size == BYTE);
   assign w_is_half = (d_size == HALF);
   // Data wins a conflict unless it was the last port served.
   assign w_d_gnt   = w_idle && d_req && (!if_req || !r_last_data);
   assign w_if_gnt  = w_idle && if_req && !w_d_gnt;
   assign d_gnt     = w_d_gnt;
   assign if_gnt    = w_if_gnt;

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = if_addr;
      ram_wd   = '0;
      if (r_state != IDLE) begin
         ram_we   = 1'b1;
         ram_addr = r_addr;
         ram_wd   = r_wd;
      end else if (w_d_gnt) begin
         ram_addr = d_addr;
         if (d_we && !w_is_byte) begin
            ram_we = 1'b1;
            ram_wd = d_wdata[15:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_data <= 1'b0;
         r_addr      <= '0;
         r_wd        <= '0;
         if_rvalid   <= 1'b0;
         if_rdata    <= '0;
         d_rvalid    <= 1'b0;
         d_rdata     <= '0;
         d_wack      <= 1'b0;
      end else begin
         if_rvalid <= w_if_gnt;
         d_rvalid  <= w_d_gnt && !d_we;
         d_wack    <= (r_state != IDLE) || (w_d_gnt && d_we && w_is_half);
         if (w_if_gnt) begin
            if_rdata    <= ram_data;
            r_last_data <= 1'b0;
         end
         if (w_d_gnt) begin
            r_last_data <= 1'b1;
            if (!d_we) d_rdata <= ram_data;
         end
         if (r_state != IDLE) begin
            r_state <= IDLE;
         end else if (w_d_gnt && d_we && !w_is_half) begin
            if (w_is_byte) begin
               // Keep the neighbouring byte read this cycle; rewrite the pair next cycle.
               r_state <= RMW_WR;
               r_addr  <= d_addr;
               r_wd    <= {ram_data[15:8], d_wdata[7:0]};
            end else begin
               r_state <= WR_HI;
               r_addr  <= d_addr + 16'd2;
               r_wd    <= d_wdata[31:16];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-array RAM model.
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [1:0]  d_size;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt, d_rvalid, d_wack;
   logic [31:0] d_rdata;
   logic        ram_we;
   logic [15:0] ram_addr, ram_wd;
   logic [31:0] ram_data;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_wack(d_wack),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
      .ram_data(ram_data)
   );

   assign ram_data = {mem[ram_addr + 16'd3], mem[ram_addr + 16'd2],
                      mem[ram_addr + 16'd1], mem[ram_addr]};

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]         <= ram_wd[7:0];
         mem[ram_addr + 16'd1] <= ram_wd[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      #0;
      mem[16'h0010] <= 8'h44; mem[16'h0011] <= 8'h33;
      mem[16'h0012] <= 8'h22; mem[16'h0013] <= 8'h11;
      mem[16'h0030] <= 8'h11; mem[16'h0031] <= 8'h22;
      mem[16'h0032] <= 8'h33; mem[16'h0033] <= 8'h44;
      rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
      d_size = 0; d_addr = 0; d_wdata = 0;
      #12;
      chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("rst_d_rvalid",  {31'b0, d_rvalid},  32'd0);
      chk("rst_d_wack",    {31'b0, d_wack},    32'd0);
      chk("rst_if_rdata",  if_rdata, 32'd0);
      chk("rst_d_rdata",   d_rdata,  32'd0);
      chk("rst_ram_we",    {31'b0, ram_we},    32'd0);
      @(negedge clk); rst = 1'b0;

      // Conflict alternation: data, fetch, data, fetch
      step();
      if_req = 1; if_addr = 16'h0010; d_req = 1; d_we = 0; d_size = 2; d_addr = 16'h0010;
      #1;
      chk("cf0_d_gnt",  {31'b0, d_gnt},  32'd1);
      chk("cf0_if_gnt", {31'b0, if_gnt}, 32'd0);
      step();
      chk("cf0_d_rvalid", {31'b0, d_rvalid}, 32'd1);
      chk("cf0_d_rdata",  d_rdata, 32'h11223344);
      #1;
      chk("cf1_if_gnt", {31'b0, if_gnt}, 32'd1);
      chk("cf1_d_gnt",  {31'b0, d_gnt},  32'd0);
      step();
      chk("cf1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("cf1_d_rvalid",  {31'b0, d_rvalid},  32'd0);
      #1;
      chk("cf2_d_gnt",  {31'b0, d_gnt},  32'd1);
      step(); #1;
      chk("cf3_if_gnt", {31'b0, if_gnt}, 32'd1);
      step();
      if_req = 0; d_req = 0;

      // Fetch only
      step();
      if_req = 1; if_addr = 16'h0010;
      #1;
      chk("fe_if_gnt",   {31'b0, if_gnt}, 32'd1);
      chk("fe_ram_addr", {16'b0, ram_addr}, 32'h0010);
      chk("fe_ram_we",   {31'b0, ram_we}, 32'd0);
      step();
      if_req = 0;
      chk("fe_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("fe_if_rdata",  if_rdata, 32'h11223344);
      step();
      chk("fe_rvalid_pulse", {31'b0, if_rvalid}, 32'd0);
      chk("fe_rdata_hold",   if_rdata, 32'h11223344);

      // Word store then load back
      d_req = 1; d_we = 1; d_size = 2; d_addr = 16'h0020; d_wdata = 32'hDEADBEEF;
      #1;
      chk("ws0_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("ws0_ram_we", {31'b0, ram_we}, 32'd1);
      chk("ws0_ram_addr", {16'b0, ram_addr}, 32'h0020);
      chk("ws0_ram_wd", {16'b0, ram_wd}, 32'hBEEF);
      step();
      d_req = 0;
      chk("ws1_d_wack", {31'b0, d_wack}, 32'd0);
      #1;
      chk("ws1_ram_we", {31'b0, ram_we}, 32'd1);
      chk("ws1_ram_addr", {16'b0, ram_addr}, 32'h0022);
      chk("ws1_ram_wd", {16'b0, ram_wd}, 32'hDEAD);
      step();
      chk("ws2_d_wack", {31'b0, d_wack}, 32'd1);
      d_req = 1; d_we = 0; d_addr = 16'h0020;
      step();
      d_req = 0;
      chk("ws_load", d_rdata, 32'hDEADBEEF);
      chk("ws_wack_pulse", {31'b0, d_wack}, 32'd0);

      // Byte store read-modify-write
      d_req = 1; d_we = 1; d_size = 0; d_addr = 16'h0030; d_wdata = 32'h000000AA;
      #1;
      chk("bs0_ram_we", {31'b0, ram_we}, 32'd0);
      step();
      d_req = 0;
      #1;
      chk("bs1_ram_we", {31'b0, ram_we}, 32'd1);
      chk("bs1_ram_wd", {16'b0, ram_wd}, 32'h22AA);
      chk("bs1_ram_addr", {16'b0, ram_addr}, 32'h0030);
      step();
      chk("bs2_d_wack", {31'b0, d_wack}, 32'd1);
      d_req = 1; d_we = 0; d_addr = 16'h0030;
      step();
      d_req = 0;
      chk("bs_load", d_rdata, 32'h443322AA);

      // Half store completes in one write
      d_req = 1; d_we = 1; d_size = 1; d_addr = 16'h0040; d_wdata = 32'h12345678;
      #1;
      chk("hs_ram_wd", {16'b0, ram_wd}, 32'h5678);
      step();
      d_req = 0;
      chk("hs_d_wack", {31'b0, d_wack}, 32'd1);

      // Busy hold-off and address wrap
      d_req = 1; d_we = 1; d_size = 2; d_addr = 16'hFFFE; d_wdata = 32'hCAFEF00D;
      step();
      d_req = 0; if_req = 1; if_addr = 16'h0010;
      #1;
      chk("wr_busy_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("wr_hi_addr", {16'b0, ram_addr}, 32'h0000);
      chk("wr_hi_wd", {16'b0, ram_wd}, 32'hCAFE);
      step();
      chk("wr_d_wack", {31'b0, d_wack}, 32'd1);
      #1;
      chk("wr_if_gnt_after", {31'b0, if_gnt}, 32'd1);
      step();
      if_req = 0;
      chk("wr_if_rdata", if_rdata, 32'h11223344);
      d_req = 1; d_we = 0; d_addr = 16'hFFFE;
      step();
      d_req = 0;
      chk("wr_wrap_load", d_rdata, 32'hCAFEF00D);

      // Reset during WR_HI
      d_req = 1; d_we = 1; d_size = 2; d_addr = 16'h0050; d_wdata = 32'h87654321;
      step();
      d_req = 0;
      #1;
      chk("rw_ram_we_pre", {31'b0, ram_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rw_ram_we", {31'b0, ram_we}, 32'd0);
      chk("rw_if_rdata", if_rdata, 32'd0);
      chk("rw_d_rdata", d_rdata, 32'd0);
      chk("rw_d_wack", {31'b0, d_wack}, 32'd0);
      @(negedge clk); rst = 1'b0;
      step();
      chk("rw_no_wack", {31'b0, d_wack}, 32'd0);
      d_req = 1; d_we = 0; d_addr = 16'h0050;
      step();
      d_req = 0;
      chk("rw_load", d_rdata, 32'h00004321);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
